// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Package  : seg7_pkg
// Purpose  : Shared font table, scan FSM states and select constants for the
//            seven-segment scan decoder.
// Revision : 1.0 - initial release
// ============================================================================

package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_t;

  // All digit selects released (blanking interval between digits).
  localparam logic [3:0] c_blank_sel = 4'b1111;

  // Active-low hex font, DP bit high; entry i is the pattern for nibble i.
  localparam logic [15:0][7:0] c_font = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic is_legal_sel(input logic [3:0] sel);
    return (sel == 4'b1110) || (sel == 4'b1101) ||
           (sel == 4'b1011) || (sel == 4'b0111);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pattern_decode
// Purpose  : Combinational lookup of a 7-bit active-low segment pattern into a
//            hex nibble; unknown patterns give nibble 0 with o_invalid set.
// Revision : 1.0 - initial release
// ============================================================================

module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nibble,
  output logic       o_invalid
);

  always_comb begin
    o_nibble  = 4'h0;
    o_invalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i_seg == c_font[i][6:0]) begin
        o_nibble  = 4'(i);
        o_invalid = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_decoder
// Purpose  : Snoops a multiplexed 4-digit seven-segment display bus and
//            rebuilds the displayed 16-bit hex value, per-digit pattern errors
//            and a stale-frame flag.
// Options  : define SEG_SCAN_DP_EN to add the DpOut decimal-point output.
// Revision : 1.0 - initial release
// ============================================================================

module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [7:0]  SegIn,
  input  logic [3:0]  BitsIn,
  output logic [15:0] Value,
  output logic        Valid,
  output logic [3:0]  SegErr,
  output logic        Stale
`ifdef SEG_SCAN_DP_EN
  ,
  output logic [3:0]  DpOut
`endif
);

  localparam int                c_to_w       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]        c_settle_max = 8'(SETTLE_CYCLES);
  localparam logic [c_to_w-1:0] c_to_max     = c_to_w'(TIMEOUT_CYCLES);

  // --------------------------------------------------------------------------
  // Input synchronizers plus one delayed copy for change detection
  // --------------------------------------------------------------------------
  logic [7:0] r_seg_meta, r_seg_sync, r_seg_prev;
  logic [3:0] r_bits_meta, r_bits_sync, r_bits_prev;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_seg_meta  <= 8'hFF;
      r_seg_sync  <= 8'hFF;
      r_seg_prev  <= 8'hFF;
      r_bits_meta <= c_blank_sel;
      r_bits_sync <= c_blank_sel;
      r_bits_prev <= c_blank_sel;
    end else begin
      r_seg_meta  <= SegIn;
      r_seg_sync  <= r_seg_meta;
      r_seg_prev  <= r_seg_sync;
      r_bits_meta <= BitsIn;
      r_bits_sync <= r_bits_meta;
      r_bits_prev <= r_bits_sync;
    end
  end

  logic w_bits_changed;
  logic w_seg_changed;
  logic w_sel_legal;
  logic [3:0] w_sel_mask;

  assign w_bits_changed = (r_bits_sync != r_bits_prev);
  assign w_sel_legal    = is_legal_sel(r_bits_sync);
  assign w_sel_mask     = ~r_bits_sync;

`ifdef SEG_SCAN_DP_EN
  assign w_seg_changed = (r_seg_sync != r_seg_prev);
`else
  // Without the DP feature a toggling decimal point must not disturb settling.
  logic w_unused_dp;
  assign w_unused_dp   = r_seg_sync[7] ^ r_seg_prev[7];
  assign w_seg_changed = (r_seg_sync[6:0] != r_seg_prev[6:0]);
`endif

  // --------------------------------------------------------------------------
  // Scan FSM
  // --------------------------------------------------------------------------
  scan_state_t r_state, w_state_next;
  logic [7:0]  r_settle_cnt, w_settle_next;
  logic        w_sample;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= 8'd0;
    end else begin
      r_state      <= w_state_next;
      r_settle_cnt <= w_settle_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_settle_next = r_settle_cnt;
    w_sample      = 1'b0;
    if (!w_sel_legal) begin
      w_state_next  = ST_IDLE;
      w_settle_next = 8'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_next  = ST_SETTLE;
          w_settle_next = 8'd1;
        end
        ST_SETTLE: begin
          if (w_bits_changed || w_seg_changed) begin
            w_settle_next = 8'd1;
          end else if (r_settle_cnt + 8'd1 == c_settle_max) begin
            w_sample      = 1'b1;
            w_state_next  = ST_HOLD;
            w_settle_next = 8'd0;
          end else begin
            w_settle_next = r_settle_cnt + 8'd1;
          end
        end
        ST_HOLD: begin
          if (w_bits_changed) begin
            w_state_next  = ST_SETTLE;
            w_settle_next = 8'd1;
          end
        end
        default: begin
          w_state_next  = ST_IDLE;
          w_settle_next = 8'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Pattern decode and frame assembly
  // --------------------------------------------------------------------------
  logic [3:0] w_nibble;
  logic       w_invalid;

  seg7_pattern_decode u_decode (
    .i_seg     (r_seg_sync[6:0]),
    .o_nibble  (w_nibble),
    .o_invalid (w_invalid)
  );

  logic [3:0][3:0] r_shadow;
  logic [3:0]      r_err_pend;
  logic [3:0]      r_seen;
  logic            w_frame_done;

  assign w_frame_done = (r_seen == 4'hF);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_shadow   <= '0;
      r_err_pend <= 4'h0;
      r_seen     <= 4'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_sample && w_sel_mask[i]) begin
          r_shadow[i]   <= w_nibble;
          r_err_pend[i] <= w_invalid;
          r_seen[i]     <= 1'b1;
        end else if (w_frame_done) begin
          r_err_pend[i] <= 1'b0;
          r_seen[i]     <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      Value  <= 16'h0000;
      Valid  <= 1'b0;
      SegErr <= 4'h0;
    end else begin
      Valid <= w_frame_done;
      if (w_frame_done) begin
        Value  <= r_shadow;
        SegErr <= r_err_pend;
      end
    end
  end

`ifdef SEG_SCAN_DP_EN
  logic [3:0] r_dp_shadow;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_dp_shadow <= 4'h0;
      DpOut       <= 4'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_sample && w_sel_mask[i]) begin
          r_dp_shadow[i] <= ~r_seg_sync[7];
        end
      end
      if (w_frame_done) begin
        DpOut <= r_dp_shadow;
      end
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Stale-frame timeout; a completing frame takes priority over saturation
  // --------------------------------------------------------------------------
  logic [c_to_w-1:0] r_to_cnt;
  logic [c_to_w-1:0] w_to_next;

  assign w_to_next = (r_to_cnt == c_to_max) ? r_to_cnt : r_to_cnt + 1'b1;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_to_cnt <= '0;
      Stale    <= 1'b0;
    end else if (w_frame_done) begin
      r_to_cnt <= '0;
      Stale    <= 1'b0;
    end else begin
      r_to_cnt <= w_to_next;
      Stale    <= (w_to_next == c_to_max);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_decoder
// Purpose  : Directed, table-driven bench for seg_scan_decoder (SETTLE 16,
//            TIMEOUT 100). DpOut is checked when SEG_SCAN_DP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================

module tb_seg_scan_decoder;

  logic        CLK;
  logic        Reset;
  logic [7:0]  SegIn;
  logic [3:0]  BitsIn;
  logic [15:0] Value;
  logic        Valid;
  logic [3:0]  SegErr;
  logic        Stale;
`ifdef SEG_SCAN_DP_EN
  logic [3:0]  DpOut;
`endif

  seg_scan_decoder #(
    .SETTLE_CYCLES  (16),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .SegIn  (SegIn),
    .BitsIn (BitsIn),
    .Value  (Value),
    .Valid  (Valid),
    .SegErr (SegErr),
    .Stale  (Stale)
`ifdef SEG_SCAN_DP_EN
    ,
    .DpOut  (DpOut)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int valid_cnt = 0;

  always @(negedge CLK) begin
    if (Valid === 1'b1) valid_cnt++;
  end

  typedef struct {
    logic [3:0][7:0] seg;
    int              hold;
    int              gap;
    int              exp_valid;
    logic [15:0]     exp_value;
    logic [3:0]      exp_err;
    logic [3:0]      exp_dp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] sel, input logic [7:0] seg, input int n);
    BitsIn = sel;
    SegIn  = seg;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset  = 1'b1;
    BitsIn = 4'hF;
    SegIn  = 8'hFF;
    repeat (2) @(posedge CLK);
    #1;
    Reset = 1'b0;
  endtask

  task automatic scan(input logic [3:0][7:0] segs, input int hold, input int gap);
    logic [3:0] sel;
    for (int d = 0; d < 4; d++) begin
      sel = ~(4'b0001 << d);
      drive(sel, segs[d], hold);
      if (gap > 0) drive(4'hF, 8'hFF, gap);
    end
  endtask

  int base;

  initial begin
    Reset  = 1'b1;
    SegIn  = 8'hFF;
    BitsIn = 4'hF;

    //            seg (digit3..digit0)  hold gap nv  value     err   dp
    vecs[0] = '{32'hB0A4F9C0, 20, 0, 1, 16'h3210, 4'h0, 4'h0};
    vecs[1] = '{32'hB0A4F9C0, 10, 0, 0, 16'h0000, 4'h0, 4'h0};
    vecs[2] = '{32'hB0A47FC0, 20, 5, 1, 16'h3200, 4'h2, 4'h2};
    vecs[3] = '{32'h8E889280, 20, 0, 1, 16'hFA58, 4'h0, 4'h0};
    vecs[4] = '{32'h90F88299, 20, 0, 1, 16'h9764, 4'h0, 4'h0};
    vecs[5] = '{32'h86A1C683, 20, 3, 1, 16'hEDCB, 4'h0, 4'h0};
    vecs[6] = '{32'h557E3F7F, 20, 0, 1, 16'h0000, 4'hF, 4'hF};
    vecs[7] = '{32'h30247940, 20, 0, 1, 16'h3210, 4'h0, 4'hF};
    vecs[8] = '{32'h40C0C0C0, 20, 0, 1, 16'h0000, 4'h0, 4'h8};

    repeat (3) @(posedge CLK);
    #1;
    check("rst_value", 32'(Value), 32'h0);
    check("rst_valid", 32'(Valid), 32'h0);
    check("rst_segerr", 32'(SegErr), 32'h0);
    check("rst_stale", 32'(Stale), 32'h0);
`ifdef SEG_SCAN_DP_EN
    check("rst_dpout", 32'(DpOut), 32'h0);
`endif
    Reset = 1'b0;
    drive(4'hF, 8'hFF, 4);
    check("post_rst_valid", 32'(valid_cnt), 32'h0);

    for (int v = 0; v < 9; v++) begin
      do_reset();
      base = valid_cnt;
      scan(vecs[v].seg, vecs[v].hold, vecs[v].gap);
      drive(4'hF, 8'hFF, 6);
      check($sformatf("vec%0d_valid_count", v), 32'(valid_cnt - base), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d_value", v), 32'(Value), 32'(vecs[v].exp_value));
      check($sformatf("vec%0d_segerr", v), 32'(SegErr), 32'(vecs[v].exp_err));
`ifdef SEG_SCAN_DP_EN
      check($sformatf("vec%0d_dpout", v), 32'(DpOut), 32'(vecs[v].exp_dp));
`endif
    end

    // Reset after two digits (selects 1011, 0111) must discard them.
    do_reset();
    base = valid_cnt;
    drive(4'b1011, 8'hF8, 20);
    drive(4'b0111, 8'hF8, 20);
    check("partial_no_valid", 32'(valid_cnt - base), 32'h0);
    do_reset();
    scan(32'h8E889280, 20, 0);
    drive(4'hF, 8'hFF, 6);
    check("midrst_valid_count", 32'(valid_cnt - base), 32'h1);
    check("midrst_value", 32'(Value), 32'hFA58);

    // Segment change while settling restarts the count: digit 0 never sampled.
    do_reset();
    base = valid_cnt;
    drive(4'b1110, 8'hC0, 10);
    drive(4'b1110, 8'hF9, 10);
    drive(4'b1101, 8'hF9, 20);
    drive(4'b1011, 8'hA4, 20);
    drive(4'b0111, 8'hB0, 20);
    drive(4'hF, 8'hFF, 6);
    check("settle_restart_no_valid", 32'(valid_cnt - base), 32'h0);
    drive(4'b1110, 8'hC0, 20);
    drive(4'hF, 8'hFF, 6);
    check("settle_restart_late_valid", 32'(valid_cnt - base), 32'h1);
    check("settle_restart_value", 32'(Value), 32'h3210);

    // Segment change after sampling (HOLD) is ignored.
    do_reset();
    base = valid_cnt;
    drive(4'b1110, 8'hC0, 20);
    drive(4'b1110, 8'hF9, 20);
    drive(4'b1101, 8'hF9, 20);
    drive(4'b1011, 8'hA4, 20);
    drive(4'b0111, 8'hB0, 20);
    drive(4'hF, 8'hFF, 6);
    check("hold_ignore_valid", 32'(valid_cnt - base), 32'h1);
    check("hold_ignore_value", 32'(Value), 32'h3210);

    // Re-sampling a digit overwrites its nibble and clears its error.
    do_reset();
    base = valid_cnt;
    drive(4'b1110, 8'hC0, 20);
    drive(4'b1101, 8'h7F, 20);
    drive(4'hF, 8'hFF, 5);
    drive(4'b1101, 8'hF9, 20);
    drive(4'b1011, 8'hA4, 20);
    drive(4'b0111, 8'hB0, 20);
    drive(4'hF, 8'hFF, 6);
    check("resample_valid", 32'(valid_cnt - base), 32'h1);
    check("resample_value", 32'(Value), 32'h3210);
    check("resample_segerr", 32'(SegErr), 32'h0);

    // Two back-to-back frames give two pulses.
    do_reset();
    base = valid_cnt;
    scan(32'hB0A4F9C0, 20, 0);
    check("b2b_first_value", 32'(Value), 32'h3210);
    scan(32'h8E889280, 20, 0);
    drive(4'hF, 8'hFF, 6);
    check("b2b_valid_count", 32'(valid_cnt - base), 32'h2);
    check("b2b_second_value", 32'(Value), 32'hFA58);

    // Timeout: Stale rises at cycle 100 of blanking, drops on the next frame.
    do_reset();
    base = valid_cnt;
    drive(4'hF, 8'hFF, 97);
    check("stale_before_timeout", 32'(Stale), 32'h0);
    drive(4'hF, 8'hFF, 6);
    check("stale_after_timeout", 32'(Stale), 32'h1);
    drive(4'hF, 8'hFF, 50);
    check("stale_saturated", 32'(Stale), 32'h1);
    drive(4'b1110, 8'hC0, 20);
    drive(4'b1101, 8'hF9, 20);
    drive(4'b1011, 8'hA4, 20);
    check("stale_held_midscan", 32'(Stale), 32'h1);
    drive(4'b0111, 8'hB0, 20);
    drive(4'hF, 8'hFF, 6);
    check("stale_frame_valid", 32'(valid_cnt - base), 32'h1);
    check("stale_cleared", 32'(Stale), 32'h0);
    check("stale_frame_value", 32'(Value), 32'h3210);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: consecutive stable cycles before a digit is sampled (legal range 2..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 1_000_000: cycles without a completed frame before Stale asserts.
REQ-003 Port CLK, input, 1 bit: the only clock.
REQ-004 Port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port SegIn, input, 8 bits: active-low segment lines; [6:0] = g..a and [7] = decimal point.
REQ-006 Port BitsIn, input, 4 bits: active-low digit-select lines.
REQ-007 Port Value, output, 16 bits: the last complete frame reconstructed as four hex nibbles.
REQ-008 Port Valid, output, 1 bit: one-cycle pulse when Value updates.
REQ-009 Port SegErr, output, 4 bits: per digit, an invalid segment pattern was seen in the last frame.
REQ-010 Port Stale, output, 1 bit: no frame has completed within TIMEOUT_CYCLES.

Function
REQ-011 SegIn and BitsIn shall each pass a two-flop synchronizer; all further logic uses the synchronized copies.
REQ-012 Digit mapping shall be: BitsIn 1110 -> Value[3:0], 1101 -> [7:4], 1011 -> [11:8], 0111 -> [15:12].
REQ-013 Any BitsIn value that is not exactly one low bit (including 1111 blanking) shall return the FSM to IDLE and clear the settle counter.
REQ-014 The FSM shall have states IDLE, SETTLE, HOLD:
  - IDLE -> SETTLE when a legal select appears.
  - SETTLE counts while both BitsIn and SegIn stay unchanged.
  - In SETTLE, any change of either input restarts the count; a change to a different legal select restarts SETTLE for that digit.
  - When the count reaches SETTLE_CYCLES, the FSM samples once and enters HOLD.
  - HOLD -> SETTLE or IDLE on any BitsIn change; a SegIn-only change in HOLD is ignored.
REQ-015 A sample shall decode SegIn[6:0] to a nibble using the standard hex font (0=C0h, 1=F9h, 2=A4h, 3=B0h, 5=92h, 8=80h, A=88h, F=8Eh, with the DP bit high).
REQ-016 A pattern outside the 16-code font shall store nibble 0 and set that digit's pending error bit.
REQ-017 Each sample shall write its nibble into a shadow register and set that digit's bit in a 4-bit seen mask.
REQ-018 Re-sampling an already-seen digit shall overwrite its shadow nibble and error bit.
REQ-019 When the seen mask becomes 1111, on the next cycle:
  - Value and SegErr are loaded from the shadow registers;
  - Valid pulses for one cycle;
  - the seen mask and pending errors clear;
  - the timeout counter clears and Stale deasserts.
  Latency from the completing sample to the Valid pulse is exactly 1 cycle.
REQ-020 The timeout counter shall saturate at TIMEOUT_CYCLES and assert Stale; Stale holds until the next Valid.
REQ-021 If a frame completes in the same cycle the counter reaches TIMEOUT_CYCLES, completion wins and Stale stays low.

Reset
REQ-022 Reset shall clear the following:
  - Value = 0000h, Valid = 0, SegErr = 0000, Stale = 0;
  - FSM = IDLE;
  - the seen mask, shadow registers and all counters;
  - the synchronizers to all-ones.
REQ-023 Reset asserted mid-frame shall discard the partial frame; no Valid pulse follows reset release until four fresh digits have been sampled.

Configuration
REQ-024 With SEG_SCAN_DP_EN defined:
  - an extra output DpOut (4 bits) is present, with the same digit mapping as Value;
  - DpOut captures the inverted SegIn[7] per digit and updates together with Value;
  - DpOut resets to 0000.
REQ-025 Without SEG_SCAN_DP_EN:
  - the DpOut port is absent;
  - SegIn[7] is ignored, including for font matching.

Structure
REQ-026 A shared package seg7_pkg shall hold:
  - the 16-entry font constant table;
  - the FSM state typedef;
  - the blank-select constant 4'b1111.
REQ-027 A combinational sub-module seg7_pattern_decode shall map 7 segment bits to a nibble plus an invalid flag; it is instantiated once.

Verification
REQ-028 Drive digits 1110/C0h, 1101/F9h, 1011/A4h, 0111/B0h, each held 20 cycles -> one Valid pulse, Value = 3210h, SegErr = 0000.
REQ-029 Hold each digit only 10 cycles (below SETTLE_CYCLES = 16) -> no sample taken, no Valid pulse.
REQ-030 Insert 1111 blanking between digits and drive digit 1101 with 7Fh -> Value = 3200h, SegErr = 0010.
REQ-031 Pulse Reset after two digits, then complete a scan of 8,5,A,F -> the first Valid pulse shows Value = FA58h, with no earlier Valid pulse.
REQ-032 Set TIMEOUT_CYCLES = 100 and hold BitsIn = 1111 -> Stale rises at cycle 100; a subsequent full scan pulses Valid and drops Stale.
REQ-033 Define SEG_SCAN_DP_EN and drive digit 0111 as 40h, others as C0h -> Value = 0000h, DpOut = 1000.
